// File: rtl/b08_feeder.sv
// Upstream driver for the b08 ROM-match stage: FIFO-buffers pushed bytes and issues
// them to b08 one at a time with b08-exact START/I timing. Optional feature: B08_FEEDER_CAPTURE_EN.
module b08_feeder #(
  parameter int DEPTH   = 4,
  parameter int RUN_LEN = 16
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic                     IN_VALID,
  input  logic [7:0]               IN_DATA,
  output logic                     IN_READY,
  output logic                     START,
  output logic [7:0]               I,
  input  logic [3:0]               O_IN,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     BUSY,
  output logic                     RES_VALID,
  output logic [7:0]               RES_TAG,
  output logic [3:0]               RES_DATA,
  output logic [2:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RUN_LEN + 3);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] DRAIN_CNT = CW'(RUN_LEN + 2);
  localparam logic [CW-1:0] RUN_CNT   = CW'(RUN_LEN);

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_ARM   = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Handshake: a byte is accepted on a rising edge where IN_VALID & IN_READY;
  // IN_READY depends only on occupancy (and reset), never on IN_VALID.

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      i_q, i_d;
  logic            start_q, start_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push, pop;

  assign push = IN_VALID && (count_q != FULL_CNT);

  // FIFO storage and pointers
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = IN_DATA;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer: next state, counter, I register and START
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    pop     = 1'b0;
    case (state_q)
      S_DRAIN: begin
        if (cnt_q == CW'(1)) state_d = S_IDLE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          i_d     = mem_q[rd_ptr_q];
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        cnt_d   = RUN_CNT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CW'(1)) state_d = S_DONE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_DRAIN;
        cnt_d   = DRAIN_CNT;
      end
    endcase
    start_d = (state_d == S_ARM);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_DRAIN;
      cnt_q    <= DRAIN_CNT;
      i_q      <= '0;
      start_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      i_q      <= i_d;
      start_q  <= start_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign IN_READY  = RESET_N && (count_q != FULL_CNT);
  assign START     = start_q;
  assign I         = i_q;
  assign COUNT     = count_q;
  assign BUSY      = (state_q != S_IDLE);
  assign dbg_state = state_q;

`ifdef B08_FEEDER_CAPTURE_EN
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_tag_q, res_tag_d;
  logic [3:0] res_data_q, res_data_d;

  // b08's O is valid throughout DONE; capture it on the edge that leaves DONE.
  always_comb begin
    res_valid_d = (state_q == S_DONE);
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;
    if (res_valid_d) begin
      res_tag_d  = i_q;
      res_data_d = O_IN;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
    end
  end

  assign RES_VALID = res_valid_q;
  assign RES_TAG   = res_tag_q;
  assign RES_DATA  = res_data_q;
`else
  logic unused_o_in;
  assign unused_o_in = ^O_IN;
  assign RES_VALID   = 1'b0;
  assign RES_TAG     = '0;
  assign RES_DATA    = '0;
`endif

endmodule

// File: tb/tb_b08_feeder.sv
// Self-checking bench for b08_feeder: randomized pushes against a cycle-count
// reference model (queue + issue times), plus directed reset/ordering scenarios.
module tb_b08_feeder;
  localparam int DEPTH     = 4;
  localparam int RUN_LEN   = 16;
  localparam int DRAIN_LEN = RUN_LEN + 2;
  localparam int ISSUE_GAP = RUN_LEN + 4;

  logic       CLOCK;
  logic       RESET_N;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic       IN_READY;
  logic       START;
  logic [7:0] I;
  logic [3:0] O_IN;
  logic [2:0] COUNT;
  logic       BUSY;
  logic       RES_VALID;
  logic [7:0] RES_TAG;
  logic [3:0] RES_DATA;
  logic [2:0] dbg_state;

  b08_feeder #(.DEPTH(DEPTH), .RUN_LEN(RUN_LEN)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(IN_READY), .START(START), .I(I), .O_IN(O_IN), .COUNT(COUNT),
    .BUSY(BUSY), .RES_VALID(RES_VALID), .RES_TAG(RES_TAG), .RES_DATA(RES_DATA),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  // reference model: FIFO contents, edge counter, the edge after which the feeder is idle
  logic [7:0] exp_q[$];
  int         m_edge;
  int         m_idle_edge;
  int         m_last_pop;
  logic       m_start;
  logic       m_pushed;
  logic [7:0] m_i;
  logic       m_res_valid;
  logic [7:0] m_res_tag;
  logic [3:0] m_res_data;
  logic [7:0] obs_q[$];
  int         start_edges[$];

  task automatic model_reset();
    exp_q.delete();
    m_edge      = 0;
    m_idle_edge = DRAIN_LEN;
    m_last_pop  = -1000;
    m_start     = 1'b0;
    m_pushed    = 1'b0;
    m_i         = 8'h00;
    m_res_valid = 1'b0;
    m_res_tag   = 8'h00;
    m_res_data  = 4'h0;
  endtask

  // one rising edge of the model, using the input values the DUT sampled
  task automatic model_edge();
    logic do_pop;
    m_edge++;
    do_pop   = (m_edge - 1 >= m_idle_edge) && (exp_q.size() > 0);
    m_pushed = IN_VALID && (exp_q.size() < DEPTH);
`ifdef B08_FEEDER_CAPTURE_EN
    if (m_edge == m_last_pop + ISSUE_GAP - 1) begin
      m_res_valid = 1'b1;
      m_res_tag   = m_i;
      m_res_data  = O_IN;
    end else begin
      m_res_valid = 1'b0;
    end
`endif
    if (do_pop) begin
      m_i         = exp_q.pop_front();
      m_last_pop  = m_edge;
      m_idle_edge = m_edge + ISSUE_GAP - 1;
    end
    if (m_pushed) exp_q.push_back(IN_DATA);
    m_start = do_pop;
  endtask

  // driver: advance one clock, step the model, settle to sample point
  task automatic tick();
    @(posedge CLOCK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00; O_IN = 4'h0;
    repeat (3) @(posedge CLOCK);
    #1;
    n_cmp++; if (START !== 1'b0)    begin n_err++; $display("FAIL rst_start: got %b want 0", START); end
    n_cmp++; if (COUNT !== 3'd0)    begin n_err++; $display("FAIL rst_count: got %0d want 0", COUNT); end
    n_cmp++; if (BUSY !== 1'b1)     begin n_err++; $display("FAIL rst_busy: got %b want 1", BUSY); end
    n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", IN_READY); end
    n_cmp++; if (I !== 8'h00)       begin n_err++; $display("FAIL rst_i: got %h want 00", I); end
    n_cmp++; if (RES_VALID !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %b want 0", RES_VALID); end
    model_reset();
    RESET_N = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      n_cmp++; if (START !== 1'b0) begin n_err++; $display("FAIL idle_start edge %0d: got %b want 0", c, START); end
      n_cmp++; if (BUSY !== (c < DRAIN_LEN)) begin n_err++; $display("FAIL drain_busy edge %0d: got %b want %b", c, BUSY, c < DRAIN_LEN); end
      n_cmp++; if (COUNT !== 3'd0) begin n_err++; $display("FAIL idle_count edge %0d: got %0d want 0", c, COUNT); end
    end
  endtask

  task automatic test_single();
    int push_edge;
    int n_start;
    n_start = 0;
    IN_VALID = 1'b1; IN_DATA = 8'hA5;
    tick();
    push_edge = m_edge;
    IN_VALID = 1'b0; IN_DATA = 8'h00;
    for (int c = 0; c < 25; c++) begin
      O_IN = 4'($urandom_range(0, 15));
      tick();
      if (START === 1'b1) n_start++;
      n_cmp++; if (START !== m_start) begin n_err++; $display("FAIL single_start edge %0d: got %b want %b", m_edge, START, m_start); end
      n_cmp++; if (I !== m_i) begin n_err++; $display("FAIL single_i edge %0d: got %h want %h", m_edge, I, m_i); end
      n_cmp++; if (BUSY !== (m_edge < m_idle_edge)) begin n_err++; $display("FAIL single_busy edge %0d: got %b want %b", m_edge, BUSY, m_edge < m_idle_edge); end
      n_cmp++; if (RES_VALID !== m_res_valid) begin n_err++; $display("FAIL single_res_valid edge %0d: got %b want %b", m_edge, RES_VALID, m_res_valid); end
`ifdef B08_FEEDER_CAPTURE_EN
      if (m_edge == push_edge + ISSUE_GAP) begin
        n_cmp++; if (RES_VALID !== 1'b1 || RES_TAG !== 8'hA5) begin n_err++; $display("FAIL single_res_at_20: got v=%b tag=%h want v=1 tag=a5", RES_VALID, RES_TAG); end
      end
`endif
    end
    n_cmp++; if (n_start != 1) begin n_err++; $display("FAIL single_start_pulses: got %0d want 1", n_start); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    logic       saw_full;
    int         guard;
    bytes = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h7E};
    obs_q.delete(); start_edges.delete();
    saw_full = 1'b0;
    for (int b = 0; b < 5; b++) begin
      IN_VALID = 1'b1; IN_DATA = bytes[b];
      guard = 0;
      do begin
        tick();
        guard++;
        if (START === 1'b1) begin obs_q.push_back(I); start_edges.push_back(m_edge); end
        if (COUNT === 3'(DEPTH)) saw_full = 1'b1;
        n_cmp++; if (COUNT !== 3'(exp_q.size())) begin n_err++; $display("FAIL b2b_count edge %0d: got %0d want %0d", m_edge, COUNT, exp_q.size()); end
        n_cmp++; if (IN_READY !== (exp_q.size() < DEPTH)) begin n_err++; $display("FAIL b2b_ready edge %0d: got %b want %b", m_edge, IN_READY, exp_q.size() < DEPTH); end
      end while (!m_pushed && guard < 100);
      n_cmp++; if (!m_pushed) begin n_err++; $display("FAIL b2b_push_timeout byte %0d: got no accept want accept", b); end
    end
    IN_VALID = 1'b0;
    for (int c = 0; c < 5 * ISSUE_GAP + 10; c++) begin
      tick();
      if (START === 1'b1) begin obs_q.push_back(I); start_edges.push_back(m_edge); end
      n_cmp++; if (START !== m_start) begin n_err++; $display("FAIL b2b_start edge %0d: got %b want %b", m_edge, START, m_start); end
      n_cmp++; if (I !== m_i) begin n_err++; $display("FAIL b2b_i edge %0d: got %h want %h", m_edge, I, m_i); end
    end
    n_cmp++; if (!saw_full) begin n_err++; $display("FAIL b2b_full: got never full want COUNT=%0d", DEPTH); end
    n_cmp++; if (obs_q.size() != 5) begin n_err++; $display("FAIL b2b_issued: got %0d want 5", obs_q.size()); end
    for (int b = 0; b < 5 && b < obs_q.size(); b++) begin
      n_cmp++; if (obs_q[b] !== bytes[b]) begin n_err++; $display("FAIL b2b_order[%0d]: got %h want %h", b, obs_q[b], bytes[b]); end
    end
    for (int b = 1; b < start_edges.size(); b++) begin
      n_cmp++; if (start_edges[b] - start_edges[b-1] != ISSUE_GAP) begin n_err++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", b, start_edges[b] - start_edges[b-1], ISSUE_GAP); end
    end
  endtask

  task automatic test_push_pop_same();
    logic [7:0] bytes [5];
    int         guard;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    obs_q.delete();
    for (int b = 0; b < 4; b++) begin
      IN_VALID = 1'b1; IN_DATA = bytes[b];
      tick();
      if (START === 1'b1) obs_q.push_back(I);
    end
    IN_VALID = 1'b0;
    n_cmp++; if (COUNT !== 3'(DEPTH - 1)) begin n_err++; $display("FAIL pps_fill: got %0d want %0d", COUNT, DEPTH - 1); end
    guard = 0;
    while (m_edge < m_idle_edge && guard < 100) begin
      tick();
      guard++;
      if (START === 1'b1) obs_q.push_back(I);
    end
    IN_VALID = 1'b1; IN_DATA = bytes[4];
    tick();
    IN_VALID = 1'b0;
    if (START === 1'b1) obs_q.push_back(I);
    n_cmp++; if (COUNT !== 3'(DEPTH - 1)) begin n_err++; $display("FAIL pps_count: got %0d want %0d", COUNT, DEPTH - 1); end
    n_cmp++; if (START !== 1'b1) begin n_err++; $display("FAIL pps_pop_start: got %b want 1", START); end
    for (int c = 0; c < 5 * ISSUE_GAP; c++) begin
      tick();
      if (START === 1'b1) obs_q.push_back(I);
    end
    n_cmp++; if (obs_q.size() != 5) begin n_err++; $display("FAIL pps_issued: got %0d want 5", obs_q.size()); end
    for (int b = 0; b < 5 && b < obs_q.size(); b++) begin
      n_cmp++; if (obs_q[b] !== bytes[b]) begin n_err++; $display("FAIL pps_order[%0d]: got %h want %h", b, obs_q[b], bytes[b]); end
    end
  endtask

  task automatic test_reset_mid();
    int n_start;
    int guard;
    IN_VALID = 1'b1; IN_DATA = 8'h9C; tick();
    IN_DATA = 8'h5A; tick();
    IN_VALID = 1'b0;
    guard = 0;
    while (m_edge != m_last_pop + 8 && guard < 100) begin tick(); guard++; end
    #2;
    RESET_N = 1'b0;
    #1;
    n_cmp++; if (START !== 1'b0)    begin n_err++; $display("FAIL mid_start: got %b want 0", START); end
    n_cmp++; if (COUNT !== 3'd0)    begin n_err++; $display("FAIL mid_count: got %0d want 0", COUNT); end
    n_cmp++; if (BUSY !== 1'b1)     begin n_err++; $display("FAIL mid_busy: got %b want 1", BUSY); end
    n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b want 0", IN_READY); end
    @(posedge CLOCK);
    #1;
    model_reset();
    RESET_N = 1'b1;
    n_start = 0;
    for (int c = 1; c <= DRAIN_LEN + 4; c++) begin
      tick();
      if (START === 1'b1 && c <= DRAIN_LEN) n_start++;
      n_cmp++; if (BUSY !== (c < DRAIN_LEN)) begin n_err++; $display("FAIL mid_drain_busy edge %0d: got %b want %b", c, BUSY, c < DRAIN_LEN); end
      n_cmp++; if (START !== m_start) begin n_err++; $display("FAIL mid_start_after edge %0d: got %b want %b", c, START, m_start); end
    end
    n_cmp++; if (n_start != 0) begin n_err++; $display("FAIL mid_no_start: got %0d want 0", n_start); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      IN_VALID = ($urandom_range(0, 3) != 0);
      IN_DATA  = 8'($urandom);
      O_IN     = 4'($urandom);
      tick();
      n_cmp++; if (COUNT !== 3'(exp_q.size())) begin n_err++; $display("FAIL rnd_count edge %0d: got %0d want %0d", m_edge, COUNT, exp_q.size()); end
      n_cmp++; if (IN_READY !== (exp_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready edge %0d: got %b want %b", m_edge, IN_READY, exp_q.size() < DEPTH); end
      n_cmp++; if (START !== m_start) begin n_err++; $display("FAIL rnd_start edge %0d: got %b want %b", m_edge, START, m_start); end
      n_cmp++; if (I !== m_i) begin n_err++; $display("FAIL rnd_i edge %0d: got %h want %h", m_edge, I, m_i); end
      n_cmp++; if (BUSY !== (m_edge < m_idle_edge)) begin n_err++; $display("FAIL rnd_busy edge %0d: got %b want %b", m_edge, BUSY, m_edge < m_idle_edge); end
      n_cmp++; if ({RES_VALID, RES_TAG, RES_DATA} !== {m_res_valid, m_res_tag, m_res_data}) begin
        n_err++; $display("FAIL rnd_res edge %0d: got %b/%h/%h want %b/%h/%h", m_edge, RES_VALID, RES_TAG, RES_DATA, m_res_valid, m_res_tag, m_res_data);
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_capture();
    int guard;
    guard = 0;
    while ((exp_q.size() > 0 || m_edge < m_idle_edge) && guard < 200) begin tick(); guard++; end
    O_IN = 4'hF;
    IN_VALID = 1'b1; IN_DATA = 8'hC3; tick();
    IN_VALID = 1'b0;
    for (int c = 0; c < ISSUE_GAP + 4; c++) begin
      tick();
      n_cmp++; if ({RES_VALID, RES_TAG, RES_DATA} !== {m_res_valid, m_res_tag, m_res_data}) begin
        n_err++; $display("FAIL cap_res edge %0d: got %b/%h/%h want %b/%h/%h", m_edge, RES_VALID, RES_TAG, RES_DATA, m_res_valid, m_res_tag, m_res_data);
      end
`ifndef B08_FEEDER_CAPTURE_EN
      n_cmp++; if ({RES_VALID, RES_TAG, RES_DATA} !== 13'd0) begin n_err++; $display("FAIL cap_tied_zero edge %0d: got %b/%h/%h want 0/00/0", m_edge, RES_VALID, RES_TAG, RES_DATA); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_push_pop_same();
    test_reset_mid();
    test_random();
    test_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
